// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants for the sequential BCD-to-binary converter (reverse double dabble).
package bcd_to_bin_seq_pkg;

   localparam int unsigned DIGIT_W  = 4;
   localparam int unsigned CNT_W    = 5;
   localparam logic [3:0]  CORR_TH  = 4'd8;
   localparam logic [3:0]  CORR_SUB = 4'd3;
   localparam logic [3:0]  DIGIT_MAX = 4'd9;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
      return d > DIGIT_MAX;
   endfunction

endpackage

// File: rtl/bcd_to_bin_seq_sub_3.sv
// Per-digit correction applied after each right shift: d >= 8 ? d - 3 : d.
module bcd_to_bin_seq_sub_3
   import bcd_to_bin_seq_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_in,
   output logic [DIGIT_W-1:0] digit_c
);

   // d >= 8 guarantees d - 3 >= 5, so the subtraction cannot wrap
   assign digit_c = (digit_in >= CORR_TH) ? (digit_in - CORR_SUB) : digit_in;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter with start/done handshake.
// Optional input digit range check enabled by defining BCD2BIN_RANGE_CHK_EN.
module bcd_to_bin_seq
   import bcd_to_bin_seq_pkg::*;
#(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
   output logic                        busy,
   output logic                        done,
   output logic [BIN_W-1:0]            bin_out,
   output logic                        err
);

   localparam int unsigned REG_W = DIGIT_W * DIGITS;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_W - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [REG_W-1:0]  bcd_q, bcd_d;
   logic [REG_W-1:0]  bin_q, bin_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [BIN_W-1:0]  bin_out_q, bin_out_d;

   logic [REG_W-1:0]  shift_bcd;
   logic [REG_W-1:0]  shift_bin;
   logic [REG_W-1:0]  corr_bcd;

   // One right shift of the concatenated {bcd, bin} register
   assign shift_bcd = {1'b0, bcd_q[REG_W-1:1]};
   assign shift_bin = {bcd_q[0], bin_q[REG_W-1:1]};

   for (genvar g = 0; g < DIGITS; g++) begin : g_corr
      bcd_to_bin_seq_sub_3 u_sub_3 (
         .digit_in (shift_bcd[g*DIGIT_W +: DIGIT_W]),
         .digit_c  (corr_bcd[g*DIGIT_W +: DIGIT_W])
      );
   end

`ifdef BCD2BIN_RANGE_CHK_EN
   logic err_q, err_d;
   logic err_flag_q, err_flag_d;
   logic any_invalid;

   always_comb begin
      any_invalid = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (digit_invalid(bcd_in[i*DIGIT_W +: DIGIT_W])) begin
            any_invalid = 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Next-state and output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      bin_d     = bin_q;
      done_d    = 1'b0;
      bin_out_d = bin_out_q;
`ifdef BCD2BIN_RANGE_CHK_EN
      err_d      = err_q;
      err_flag_d = err_flag_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bcd_d   = bcd_in;
               bin_d   = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
`ifdef BCD2BIN_RANGE_CHK_EN
               err_flag_d = any_invalid;
               if (any_invalid) begin
                  state_d = ST_DONE;
               end
`endif
            end
         end
         ST_SHIFT: begin
            bcd_d = corr_bcd;
            bin_d = shift_bin;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_d    = 1'b1;
            bin_out_d = bin_q[BIN_W-1:0];
`ifdef BCD2BIN_RANGE_CHK_EN
            err_d = err_flag_q;
            if (err_flag_q) begin
               bin_out_d = '0;
            end
`endif
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bcd_q     <= '0;
         bin_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bin_out_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         bin_q     <= bin_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bin_out_q <= bin_out_d;
      end
   end

`ifdef BCD2BIN_RANGE_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q      <= 1'b0;
         err_flag_q <= 1'b0;
      end else begin
         err_q      <= err_d;
         err_flag_q <= err_flag_d;
      end
   end
`endif

   assign busy    = busy_q;
   assign done    = done_q;
   assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: expected result, err and done cycle queued at each accepted start.
module tb_bcd_to_bin_seq;

   localparam int unsigned DIGITS = 3;
   localparam int unsigned BIN_W  = 10;
   localparam int unsigned VALID_LAT = 4 * DIGITS + 1;

   typedef struct packed {
      logic [BIN_W-1:0] bin;
      logic             err;
      logic [31:0]      cyc;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [4*DIGITS-1:0] bcd_in;
   logic              busy;
   logic              done;
   logic [BIN_W-1:0]  bin_out;
   logic              err;

   int unsigned n_tests;
   int unsigned n_fail;
   int unsigned cyc;
   exp_t        sb_q[$];

   bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  tag, obs, obs, exp, exp, cyc);
      end
   endtask

   // Reference model: decimal value of the BCD word, or the error outcome
   function automatic exp_t model(input logic [4*DIGITS-1:0] b, input int unsigned acc_edge);
      exp_t e;
      int unsigned v;
      logic bad;
      v   = 0;
      bad = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v = v * 10 + int'(b[i*4 +: 4]);
         if (b[i*4 +: 4] > 4'd9) bad = 1'b1;
      end
`ifdef BCD2BIN_RANGE_CHK_EN
      if (bad) begin
         e.bin = '0;
         e.err = 1'b1;
         e.cyc = 32'(acc_edge + 1);
         return e;
      end
`endif
      e.bin = BIN_W'(v);
      e.err = 1'b0;
      e.cyc = 32'(acc_edge + VALID_LAT);
      return e;
   endfunction

   // Output monitor: every done must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("bin_out", 32'(bin_out), 32'(e.bin));
            check_eq("err", 32'(err), 32'(e.err));
            check_eq("done_cycle", 32'(cyc), e.cyc);
         end
      end
   end

   task automatic drain(input int unsigned margin);
      for (int i = 0; i < 80 && sb_q.size() != 0; i++) @(negedge clk);
      check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
      repeat (margin) @(negedge clk);
   endtask

   task automatic run_conv(input logic [4*DIGITS-1:0] v);
      @(negedge clk);
      start  = 1'b1;
      bcd_in = v;
      sb_q.push_back(model(v, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      check_eq("busy_after_start", 32'(busy), 32'd1);
      drain(3);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      start   = 1'b0;
      bcd_in  = '0;
      rst_n   = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_bin_out", 32'(bin_out), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_conv(12'h999);
      // Asynchronous reset in idle clears the held result without a clock
      #3 rst_n = 1'b0;
      #1;
      check_eq("idle_rst_bin_out", 32'(bin_out), 32'd0);
      check_eq("idle_rst_busy", 32'(busy), 32'd0);
      check_eq("idle_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_conv(12'h000);
      run_conv(12'h128);
      run_conv(12'h255);
      run_conv(12'h500);

      // A second start while busy must be ignored
      @(negedge clk);
      start  = 1'b1;
      bcd_in = 12'h123;
      sb_q.push_back(model(12'h123, cyc + 1));
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 12'h456;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain(16);
      run_conv(12'h456);

`ifdef BCD2BIN_RANGE_CHK_EN
      run_conv(12'h1A3);
      run_conv(12'h042);
`else
      run_conv(12'h042);
`endif

      // Reset mid-conversion: no done, outputs cleared
      @(negedge clk);
      start  = 1'b1;
      bcd_in = 12'h777;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_done", 32'(done), 32'd0);
      check_eq("abort_bin_out", 32'(bin_out), 32'd0);
      check_eq("abort_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      run_conv(12'h777);

      // start held high: one conversion every 4*DIGITS+2 cycles
      begin
         int unsigned e0;
         @(negedge clk);
         start  = 1'b1;
         bcd_in = 12'h310;
         e0 = cyc + 1;
         for (int k = 0; k < 3; k++) begin
            sb_q.push_back(model(12'h310, e0 + k * (VALID_LAT + 1)));
         end
         while (cyc < e0 + 2 * (VALID_LAT + 1) + 1) @(negedge clk);
         start = 1'b0;
         drain(20);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Iterative BCD-to-binary converter using reverse double dabble.
- Each cycle it shifts right one bit, then subtracts 3 from every BCD digit that is >= 8.
- This is the inverse of the binary-to-BCD add-3 display path. The vending datapath uses it to turn keypad/UART-entered BCD prices and amounts into binary for arithmetic.
- Start/done handshake; one conversion in flight at a time.

Parameters:
- DIGITS, 3: number of BCD digits in bcd_in.
- BIN_W, 10: binary output width. Must be >= ceil(log2(10^DIGITS)); 10 covers 999.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request. Sampled only in IDLE.
- bcd_in  in  4*DIGITS  BCD operand, most significant digit in the top nibble. Sampled on the accepted start.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  single-cycle pulse; bin_out and err are valid in that cycle and held until the next done.
- bin_out  out  BIN_W  converted value.
- err  out  1  an input digit was > 9 (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, bin_out=0, err=0, all internal registers 0.
- Internal shift register is {bcd_q[4*DIGITS-1:0], bin_q[4*DIGITS-1:0]}. A 5-bit-safe counter cnt counts 0..4*DIGITS-1.
- IDLE:
  - start=1 loads bcd_q=bcd_in, bin_q=0, cnt=0, then goes to SHIFT.
  - With the range check enabled and any digit > 9: go to DONE directly and flag err.
- SHIFT, each cycle:
  - Shift the whole register right 1 (LSB of bcd_q enters MSB of bin_q).
  - Then each digit of bcd_q becomes (d >= 8) ? d-3 : d.
  - cnt++. When cnt == 4*DIGITS-1, go to DONE.
- DONE, one cycle:
  - done=1, bin_out=bin_q[BIN_W-1:0], err as flagged.
  - Invalid case: bin_out=0, err=1.
  - Then go to IDLE.
- Latency, counted from the start-sampling edge:
  - Valid operand: done is high in cycle 4*DIGITS+1 (cycle 13 at default).
  - Invalid operand: done is high in cycle 1.
- Throughput: one conversion per 4*DIGITS+2 cycles. A new start is accepted the cycle after done.
- start while busy: ignored, no queueing. bcd_in changes while busy: ignored.
- done is never asserted twice per accepted start.
- Reset mid-operation: abort immediately. No done pulse; bin_out and err cleared.
- Arithmetic: the digit correction is 4-bit unsigned and never underflows (d >= 8 implies d-3 >= 5). Bits of bin_q above BIN_W are discarded; they are zero for legal parameters.

Optional Feature:
- Macro: BCD2BIN_RANGE_CHK_EN.
- Defined: at load, each nibble is compared > 9. Any violation takes IDLE -> DONE with err=1 and bin_out=0.
- Undefined: no check. err is tied to 0, and illegal nibbles are converted arithmetically (result is unspecified but deterministic).

Decomposition:
- Shared package/header holds:
  - DIGIT_W=4
  - CORR_TH=4'd8
  - CORR_SUB=4'd3
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
- One natural sub-module: sub_3, combinational per-digit corrector (in[3:0] -> out = in>=8 ? in-3 : in). It is instantiated DIGITS times via generate.
- FSM, counter and shift register live in bcd_to_bin_seq.

Test Plan:
- Reset: assert rst_n=0 mid-idle -> busy=0, done=0, bin_out=0, err=0 immediately, without waiting for a clock.
- start with bcd_in=12'h999 -> done pulses exactly 13 cycles after the start edge, bin_out=10'd999 (0x3E7), err=0. Repeat for 12'h000 -> 0, 12'h128 -> 128, 12'h255 -> 255, 12'h500 -> 500.
- start with 12'h123, then start with 12'h456 at cycle 3 -> a single done at cycle 13 with bin_out=123. The next start of 12'h456 after done yields 456.
- Range check enabled, bcd_in=12'h1A3 -> done at cycle 1, bin_out=0, err=1. The following valid 12'h042 gives 42 with err=0.
- rst_n low at cycle 5 of a conversion of 12'h777 -> no done pulse, busy=0. A fresh start after release converts 12'h777 to 777 normally.
- Back-to-back: start held high continuously with bcd_in=12'h310 -> a done every 14 cycles, each with bin_out=310.
